instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, IF/ID payload
// layout and the default reset fetch address.
package instr_fetch_unit_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam int          IF_ID_W          = 64;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO between the memory side and decode; flush wins over
// push/pop, and push is accepted on a full buffer only when a pop frees a slot.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = i_pop && !o_empty;
    do_push  = i_push && (!o_full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while the count says empty.
  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding strobe/ack memory request at a time,
// fetched words queued in a small buffer toward decode, redirects flush and retarget.
module instr_fetch_unit import instr_fetch_unit_pkg::*; #(
  parameter int          DEPTH     = 8192,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic [$clog2(DEPTH)-1:0] o_mem_addr,
  output logic                     o_mem_stb,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_instr,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic [31:0]              o_instr,
  output logic [31:0]              o_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [1:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          stb_q, stb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   redirect_pc_aligned;
  logic          buf_push, buf_pop, buf_full, buf_empty;
  if_id_t        buf_wdata, buf_rdata;

  assign redirect_pc_aligned = i_redirect_pc & ~32'h3;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stb_d      = stb_q;
    buf_push   = 1'b0;
    buf_wdata  = '{pc: fetch_pc_q, instr: i_mem_instr};
    case (state_q)
      ST_IDLE: begin
        if (i_redirect) begin
          fetch_pc_d = redirect_pc_aligned;
        end else if (!buf_full) begin
          state_d = ST_BUSY;
          stb_d   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (i_mem_ack) begin
          state_d = ST_IDLE;
          stb_d   = 1'b0;
          if (i_redirect) begin
            fetch_pc_d = redirect_pc_aligned;
          end else begin
            buf_push   = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (i_redirect) begin
          state_d    = ST_DISCARD;
          fetch_pc_d = redirect_pc_aligned;
        end
      end
      ST_DISCARD: begin
        if (i_redirect) fetch_pc_d = redirect_pc_aligned;
        if (i_mem_ack) begin
          state_d = ST_IDLE;
          stb_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = 1'b0;
      end
    endcase
    // Address is frozen for the whole strobe; otherwise it tracks the next fetch pc.
    addr_d = (stb_q && stb_d) ? addr_q : fetch_pc_d[AW+1:2];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      stb_q      <= 1'b0;
      addr_q     <= RESET_PC[AW+1:2];
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
    end
  end

  // Decode handshake: o_instr/o_pc transfer on a clock edge where o_valid && i_ready;
  // o_valid never drops without a transfer except on redirect or reset, which flush.
  assign buf_pop = o_valid && i_ready && !i_redirect;

  fetch_buffer #(
    .WIDTH (IF_ID_W),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_redirect),
    .i_push  (buf_push),
    .i_data  (buf_wdata),
    .i_pop   (buf_pop),
    .o_data  (buf_rdata),
    .o_full  (buf_full),
    .o_empty (buf_empty)
  );

  assign o_valid     = !buf_empty;
  assign o_instr     = o_valid ? buf_rdata.instr : 32'd0;
  assign o_pc        = o_valid ? buf_rdata.pc    : 32'd0;
  assign o_mem_stb   = stb_q;
  assign o_mem_addr  = addr_q;
  assign o_dbg_state = state_q;

endmodule
